obstacle_three_sprite_core: RTL and testbench
=============================================

// Module: obstacle_three_sprite_core
// PURPOSE
// Pixel-side driver for the obstacle-three 32x32 sprite RAM. Tracks the obstacle's
//   horizontal position with a per-frame motion FSM, converts the current VGA pixel
//   (x,y) into a sprite RAM read address and consumes the RAM's 2-bit colour index
//   one cycle later. It then emits a registered 12-bit RGB value plus an "on" flag
//   to the frame mux.
// PARAMETERS
// ADDR_WIDTH      10      sprite RAM address width = 2*SIZE_BITS (row[9:5], col[4:0])
// SIZE_BITS       5       log2 of sprite edge; sprite is 32x32 pixels
// X_START         640     x_pos loaded on start/respawn (left edge, just off-screen)
// Y_POS           400     fixed top row of the sprite
// RESPAWN_FRAMES  60      frame_ticks spent in RESPAWN before re-entering
// COLOR1/2/3      12'hF00/12'h0F0/12'h00F   palette for indices 1..3; index 0 = transparent
// PORTS
// clk         in   1    system clock (pixel-rate enable domain)
// rst_n       in   1    synchronous, active-low reset
// x           in   11   current pixel column from vga sync
// y           in   11   current pixel row from vga sync
// frame_tick  in   1    1-cycle pulse, once per frame, during blanking
// start       in   1    1-cycle pulse: IDLE -> RUN
// stop        in   1    1-cycle pulse: any state -> IDLE (game over)
// speed       in   4    pixels moved left per frame_tick
// addr_r      out  10   read address to sprite RAM (registered)
// ram_dout    in   2    colour index from sprite RAM (valid 1 cycle after addr_r)
// sprite_on   out  1    registered: current pipelined pixel is opaque obstacle
// sprite_rgb  out  12   registered colour; 12'h000 when sprite_on=0
// obstacle_x  out  11   current left edge x_pos (for collision logic)
// pass_pulse  out  1    1-cycle pulse when obstacle leaves left edge (score)
// BEHAVIOUR
// - Reset (rst_n=0 at clk edge): state=IDLE, x_pos=X_START, frame count=0.
//   addr_r=0, sprite_on=0, sprite_rgb=0, pass_pulse=0, all pipeline valid bits=0.
// - FSM states IDLE, RUN, RESPAWN; stop has priority over start and frame_tick.
//   IDLE: start -> RUN, x_pos<=X_START.
//   RUN: on frame_tick, if x_pos < speed -> RESPAWN, pass_pulse=1 next cycle, count<=0.
//     Otherwise x_pos<=x_pos-speed; speed=0 leaves the obstacle stationary.
//   RESPAWN: count increments per frame_tick. Once count reaches RESPAWN_FRAMES-1
//     with frame_tick high -> RUN, x_pos<=X_START.
//   stop in any state -> IDLE next cycle; x_pos is held.
// - Hit test (12-bit arithmetic, no wrap):
//   x>=x_pos && x<x_pos+32 && y>=Y_POS && y<Y_POS+32 && state==RUN.
// - Pipeline: (x,y) presented in cycle t.
//   t+1: addr_r={y-Y_POS, x-x_pos}[9:0] and hit_d1 registered; addr_r=0 when no hit.
//   t+2: RAM returns ram_dout; hit_d2 registered.
//   t+3: sprite_on = hit_d2 && ram_dout!=0; sprite_rgb = palette[ram_dout] or 0.
//   Total latency 3 cycles; the vga sync must delay hsync/vsync to match.
// - x_pos changes only on frame_tick (blanking), so a frame never tears.
// - Partial clipping at the left edge is not supported; the obstacle vanishes when x_pos<speed.
// - Columns x>=640 never reach the display; the obstacle enters from X_START naturally.
// TESTING
// 1 Reset: rst_n=0 two cycles -> sprite_on=0, sprite_rgb=0, addr_r=0, obstacle_x=640, pass_pulse=0.
// 2 Motion: start, speed=4, 3 frame_ticks -> obstacle_x 636, 632, 628; speed=0 tick -> 628.
// 3 Pipeline: x_pos=100, pixel(105,403) at t -> addr_r=10'h065 at t+1.
//   RAM model returns 2 -> sprite_on=1, sprite_rgb=COLOR2 at t+3; returns 0 -> sprite_on=0.
// 4 Bounds, x_pos=100, opaque RAM: x=131,y=431 -> on; x=132 or y=432 or x=99 -> off, rgb=0.
// 5 Exit/respawn: x_pos=3, speed=4, tick -> pass_pulse for exactly 1 cycle, no sprite.
//   After 60 ticks -> RUN, obstacle_x=640.
// 6 Priority: start+stop same cycle in RUN -> IDLE; stop in RESPAWN -> IDLE, no pass_pulse;
//   rst_n=0 mid-RUN -> full reset values.

Source files
------------

// File: rtl/obstacle_three_sprite_core.sv
// Obstacle-three sprite driver: per-frame horizontal motion FSM plus a 3-stage
// pixel pipeline (address -> sprite RAM -> palette) feeding the frame mux.
module obstacle_three_sprite_core #(
  parameter int          ADDR_WIDTH     = 10,
  parameter int          SIZE_BITS      = 5,
  parameter int          X_START        = 640,
  parameter int          Y_POS          = 400,
  parameter int          RESPAWN_FRAMES = 60,
  parameter logic [11:0] COLOR1         = 12'hF00,
  parameter logic [11:0] COLOR2         = 12'h0F0,
  parameter logic [11:0] COLOR3         = 12'h00F
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [10:0]           x_i,
  input  logic [10:0]           y_i,
  input  logic                  frame_tick_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [3:0]            speed_i,
  output logic [ADDR_WIDTH-1:0] addr_r_o,
  input  logic [1:0]            ram_dout_i,
  output logic                  sprite_on_o,
  output logic [11:0]           sprite_rgb_o,
  output logic [10:0]           obstacle_x_o,
  output logic                  pass_pulse_o
);

  typedef enum logic [1:0] {IDLE, RUN, RESPAWN} state_t;

  localparam int               CNT_W    = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESPAWN_FRAMES - 1);
  localparam logic [10:0]      X_INIT   = 11'(X_START);
  localparam logic [11:0]      SPRITE_W = 12'(1 << SIZE_BITS);
  localparam logic [11:0]      TOP      = 12'(Y_POS);

  state_t                  state_q, state_d;
  logic [10:0]             xPos_q, xPos_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    pass_q, pass_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    hitD1_q, hitD2_q;
  logic                    on_q, on_d;
  logic [11:0]             rgb_q, rgb_d;

  logic [11:0] px, py, left, colOff, rowOff;
  logic        hit;
  logic [10:0] speedExt;

  assign speedExt = {7'b0, speed_i};

  // stop outranks everything; position only ever moves on frame_tick so a frame never tears
  always_comb begin
    state_d = state_q;
    xPos_d  = xPos_q;
    cnt_d   = cnt_q;
    pass_d  = 1'b0;
    if (stop_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d = RUN;
            xPos_d  = X_INIT;
          end
        end
        RUN: begin
          if (frame_tick_i) begin
            if (xPos_q < speedExt) begin
              state_d = RESPAWN;
              pass_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              xPos_d = xPos_q - speedExt;
            end
          end
        end
        RESPAWN: begin
          if (frame_tick_i) begin
            if (cnt_q == CNT_LAST) begin
              state_d = RUN;
              xPos_d  = X_INIT;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // hit test in 12 bits so x_pos+32 cannot wrap near the right edge
  always_comb begin
    px     = {1'b0, x_i};
    py     = {1'b0, y_i};
    left   = {1'b0, xPos_q};
    colOff = px - left;
    rowOff = py - TOP;
    hit    = (px >= left) && (px < left + SPRITE_W) &&
             (py >= TOP) && (py < TOP + SPRITE_W) && (state_q == RUN);
    addr_d = hit ? ADDR_WIDTH'({rowOff[SIZE_BITS-1:0], colOff[SIZE_BITS-1:0]}) : '0;
  end

  always_comb begin
    on_d  = hitD2_q && (ram_dout_i != 2'd0);
    rgb_d = 12'h000;
    if (on_d) begin
      case (ram_dout_i)
        2'd1:    rgb_d = COLOR1;
        2'd2:    rgb_d = COLOR2;
        2'd3:    rgb_d = COLOR3;
        default: rgb_d = 12'h000;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      xPos_q  <= X_INIT;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      addr_q  <= '0;
      hitD1_q <= 1'b0;
      hitD2_q <= 1'b0;
      on_q    <= 1'b0;
      rgb_q   <= 12'h000;
    end else begin
      state_q <= state_d;
      xPos_q  <= xPos_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      addr_q  <= addr_d;
      hitD1_q <= hit;
      hitD2_q <= hitD1_q;
      on_q    <= on_d;
      rgb_q   <= rgb_d;
    end
  end

  assign addr_r_o     = addr_q;
  assign sprite_on_o  = on_q;
  assign sprite_rgb_o = rgb_q;
  assign obstacle_x_o = xPos_q;
  assign pass_pulse_o = pass_q;

endmodule

// File: tb/tb_obstacle_three_sprite_core.sv
// Directed bench for obstacle_three_sprite_core: reset, motion, pixel pipeline,
// bounds, exit/respawn and stop/start priority, with a 1-cycle sprite RAM model.
module tb_obstacle_three_sprite_core;

  logic        clk = 1'b0;
  logic        rstN;
  logic [10:0] x, y;
  logic        frameTick, start, stop;
  logic [3:0]  speed;
  logic [9:0]  addrR;
  logic [1:0]  ramDout;
  logic [1:0]  ramFill;
  logic        spriteOn;
  logic [11:0] spriteRgb;
  logic [10:0] obstacleX;
  logic        passPulse;

  int compared   = 0;
  int mismatched = 0;

  obstacle_three_sprite_core dut (
    .clk_i        (clk),
    .rst_n_i      (rstN),
    .x_i          (x),
    .y_i          (y),
    .frame_tick_i (frameTick),
    .start_i      (start),
    .stop_i       (stop),
    .speed_i      (speed),
    .addr_r_o     (addrR),
    .ram_dout_i   (ramDout),
    .sprite_on_o  (spriteOn),
    .sprite_rgb_o (spriteRgb),
    .obstacle_x_o (obstacleX),
    .pass_pulse_o (passPulse)
  );

  always #5 clk = ~clk;

  // sprite RAM stand-in: every location holds ramFill, one cycle of read latency
  always @(posedge clk) ramDout <= ramFill;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // one clock with the given control pulses; returns #1 after the edge
  task automatic applyStimulus(input logic tick, input logic st, input logic sp);
    frameTick = tick;
    start     = st;
    stop      = sp;
    @(posedge clk);
    #1;
    frameTick = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0);
  endtask

  // present a pixel, check the address one cycle later and the colour three cycles later
  task automatic probePixel(input string tag, input logic [10:0] px, input logic [10:0] py,
                            input logic [9:0] expAddr, input logic expOn, input logic [11:0] expRgb);
    x = px;
    y = py;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput({tag, "_addr"}, 32'(addrR), 32'(expAddr));
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput({tag, "_on"}, 32'(spriteOn), 32'(expOn));
    checkOutput({tag, "_rgb"}, 32'(spriteRgb), 32'(expRgb));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN = 1'b0; x = '0; y = '0; frameTick = 1'b0; start = 1'b0; stop = 1'b0;
    speed = 4'd0; ramFill = 2'd0;

    // reset
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("rst_on",   32'(spriteOn),  32'd0);
    checkOutput("rst_rgb",  32'(spriteRgb), 32'd0);
    checkOutput("rst_addr", 32'(addrR),     32'd0);
    checkOutput("rst_x",    32'(obstacleX), 32'd640);
    checkOutput("rst_pass", 32'(passPulse), 32'd0);
    rstN = 1'b1;

    // motion
    applyStimulus(1'b0, 1'b1, 1'b0);
    speed = 4'd4;
    applyStimulus(1'b1, 1'b0, 1'b0); checkOutput("move1", 32'(obstacleX), 32'd636);
    applyStimulus(1'b1, 1'b0, 1'b0); checkOutput("move2", 32'(obstacleX), 32'd632);
    applyStimulus(1'b1, 1'b0, 1'b0); checkOutput("move3", 32'(obstacleX), 32'd628);
    speed = 4'd0;
    applyStimulus(1'b1, 1'b0, 1'b0); checkOutput("move_spd0", 32'(obstacleX), 32'd628);

    // reset mid-RUN returns to IDLE at X_START
    rstN = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    rstN = 1'b1;
    checkOutput("midrst_x",    32'(obstacleX), 32'd640);
    checkOutput("midrst_on",   32'(spriteOn),  32'd0);
    checkOutput("midrst_addr", 32'(addrR),     32'd0);
    checkOutput("midrst_pass", 32'(passPulse), 32'd0);
    speed = 4'd4;
    applyStimulus(1'b1, 1'b0, 1'b0); checkOutput("midrst_idle", 32'(obstacleX), 32'd640);

    // drive to x_pos = 100
    applyStimulus(1'b0, 1'b1, 1'b0);
    speed = 4'd15;
    ticks(36);
    checkOutput("at100", 32'(obstacleX), 32'd100);

    // pipeline
    ramFill = 2'd2;
    probePixel("pipe_c2", 11'd105, 11'd403, 10'h065, 1'b1, 12'h0F0);
    ramFill = 2'd0;
    probePixel("pipe_clear", 11'd105, 11'd403, 10'h065, 1'b0, 12'h000);

    // bounds
    ramFill = 2'd3;
    probePixel("b_corner", 11'd131, 11'd431, 10'h3FF, 1'b1, 12'h00F);
    probePixel("b_x132",   11'd132, 11'd403, 10'h000, 1'b0, 12'h000);
    probePixel("b_y432",   11'd105, 11'd432, 10'h000, 1'b0, 12'h000);
    probePixel("b_x99",    11'd99,  11'd403, 10'h000, 1'b0, 12'h000);
    ramFill = 2'd1;
    probePixel("b_origin", 11'd100, 11'd400, 10'h000, 1'b1, 12'hF00);

    // exit and respawn
    ticks(6);
    speed = 4'd7;
    applyStimulus(1'b1, 1'b0, 1'b0); checkOutput("at3", 32'(obstacleX), 32'd3);
    speed = 4'd4;
    x = 11'd5; y = 11'd405; ramFill = 2'd3;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("exit_pass", 32'(passPulse), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("exit_pass_end", 32'(passPulse), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("exit_nosprite", 32'(spriteOn), 32'd0);
    ticks(59);
    checkOutput("respawn59", 32'(obstacleX), 32'd3);
    ticks(1);
    checkOutput("respawn60", 32'(obstacleX), 32'd640);
    speed = 4'd15;
    applyStimulus(1'b1, 1'b0, 1'b0); checkOutput("respawn_run", 32'(obstacleX), 32'd625);

    // stop outranks an exiting frame_tick
    ticks(41);
    checkOutput("at10", 32'(obstacleX), 32'd10);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("stoptick_pass", 32'(passPulse), 32'd0);
    checkOutput("stoptick_x",    32'(obstacleX), 32'd10);
    applyStimulus(1'b1, 1'b0, 1'b0); checkOutput("idle_hold", 32'(obstacleX), 32'd10);

    // start+stop together in RUN lands in IDLE
    applyStimulus(1'b0, 1'b1, 1'b0); checkOutput("restart_x", 32'(obstacleX), 32'd640);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0); checkOutput("startstop_idle", 32'(obstacleX), 32'd640);

    // stop in RESPAWN: no pulse, no respawn
    applyStimulus(1'b0, 1'b1, 1'b0);
    ticks(42);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("resp_enter_pass", 32'(passPulse), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("resp_stop_pass", 32'(passPulse), 32'd0);
    ticks(60);
    checkOutput("resp_stop_x", 32'(obstacleX), 32'd10);
    checkOutput("resp_stop_pass2", 32'(passPulse), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
